preproc_axi_regs: RTL and testbench

- AXI4-Lite slave register file for the preprocessing core, mapped at base 0x4000_0000.
- It is the responder to the AXI-Lite master (PS or bench master agent).
- Decodes the preproc register map, holds the control registers and drives them to the datapath.
- Returns read-only identification words (core ID, build date).

---
 rtl/preproc_axi_regs.sv | 208 ++++++++++++++++++++
 tb/tb_preproc_axi_regs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/preproc_axi_regs.sv
// AXI4-Lite slave register file for the preprocessing core: ID/date words plus FIFO_EN, SEL_SOURCE, SEL_FIR.
// Define PREPROC_SCRATCH_REG_EN to add a 32-bit SCRATCH register at offset 0x14.
module preproc_axi_regs #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] CORE_ID    = 32'h5052_4550,
  parameter logic [31:0] DATE       = 32'h0000_0000,
  parameter int          SRC_SEL_W  = 2,
  parameter int          FIR_SEL_W  = 3
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      fifo_en,
  output logic [SRC_SEL_W-1:0]      sel_source,
  output logic [FIR_SEL_W-1:0]      sel_fir
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
`ifdef PREPROC_SCRATCH_REG_EN
  logic [DATA_WIDTH-1:0] scratch;
`endif

  logic                  aw_hs, w_hs, ar_hs, wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, wr_mask, rd_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_err, rd_err;
  logic                  unused_bits;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // A half that arrived earlier is taken from its holding register, otherwise straight from the bus,
  // so a write commits on the very edge its second half is accepted.
  assign wr_addr = aw_held ? awaddr_q : s_axi_awaddr;
  assign wr_data = w_held ? wdata_q : s_axi_wdata;
  assign wr_strb = w_held ? wstrb_q : s_axi_wstrb;
  assign wr_go   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign unused_bits = ^{wr_addr[1:0], s_axi_araddr[1:0], wr_data, wr_mask};

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < STRB_W; i++) wr_mask[i*8 +: 8] = {8{wr_strb[i]}};
  end

  always_comb begin
    wr_err = 1'b0;
    if (wr_addr[ADDR_WIDTH-1:5] != '0) wr_err = 1'b1;
    else begin
      case (wr_addr[4:2])
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: wr_err = 1'b0;
`ifdef PREPROC_SCRATCH_REG_EN
        3'd5:    wr_err = 1'b0;
`endif
        default: wr_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (s_axi_araddr[ADDR_WIDTH-1:5] != '0) rd_err = 1'b1;
    else begin
      case (s_axi_araddr[4:2])
        3'd0:    rd_data = CORE_ID;
        3'd1:    rd_data = DATE;
        3'd2:    rd_data = DATA_WIDTH'(fifo_en);
        3'd3:    rd_data = DATA_WIDTH'(sel_source);
        3'd4:    rd_data = DATA_WIDTH'(sel_fir);
`ifdef PREPROC_SCRATCH_REG_EN
        3'd5:    rd_data = scratch;
`endif
        default: rd_err = 1'b1;
      endcase
    end
  end

  // Write channel and the control registers; ID/date writes fall through the case and are dropped.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      fifo_en       <= 1'b0;
      sel_source    <= '0;
      sel_fir       <= '0;
`ifdef PREPROC_SCRATCH_REG_EN
      scratch       <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q      <= s_axi_awaddr;
            aw_held       <= 1'b1;
            s_axi_awready <= 1'b0;
          end
          if (w_hs) begin
            wdata_q      <= s_axi_wdata;
            wstrb_q      <= s_axi_wstrb;
            w_held       <= 1'b1;
            s_axi_wready <= 1'b0;
          end
          if (wr_go) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            w_state      <= W_RESP;
            if (!wr_err) begin
              case (wr_addr[4:2])
                3'd2: fifo_en <= (fifo_en & ~wr_mask[0]) | (wr_data[0] & wr_mask[0]);
                3'd3: sel_source <= (sel_source & ~wr_mask[SRC_SEL_W-1:0]) |
                                    (wr_data[SRC_SEL_W-1:0] & wr_mask[SRC_SEL_W-1:0]);
                3'd4: sel_fir <= (sel_fir & ~wr_mask[FIR_SEL_W-1:0]) |
                                 (wr_data[FIR_SEL_W-1:0] & wr_mask[FIR_SEL_W-1:0]);
`ifdef PREPROC_SCRATCH_REG_EN
                3'd5: scratch <= (scratch & ~wr_mask) | (wr_data & wr_mask);
`endif
                default: ;
              endcase
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel: data is captured on the AR handshake and held until the master takes it.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_data;
            s_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preproc_axi_regs.sv
// Self-checking bench for preproc_axi_regs: vector table plus multi-cycle corner sequences.
// Honours PREPROC_SCRATCH_REG_EN the same way as the design.
module tb_preproc_axi_regs;

  localparam logic [31:0] CORE_ID_V = 32'h5052_4550;
  localparam logic [31:0] DATE_V    = 32'h2024_0315;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;
`ifdef PREPROC_SCRATCH_REG_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        clk, reset;
  logic [6:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        fifo_en;
  logic [1:0]  sel_source;
  logic [2:0]  sel_fir;

  preproc_axi_regs #(.CORE_ID(CORE_ID_V), .DATE(DATE_V)) dut (
    .s_axi_aclk(clk), .s_axi_areset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .fifo_en(fifo_en), .sel_source(sel_source), .sel_fir(sel_fir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          order;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [5:0]  exp_ctrl;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(bit w, logic [6:0] a, logic [31:0] d, logic [3:0] s, int o,
                              logic [31:0] ed, logic [1:0] er, logic [5:0] ctrl);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.order = o;
    v.exp_data = ed; v.exp_resp = er; v.exp_ctrl = ctrl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic popCheck(input string name, input logic [31:0] act_data, input logic [1:0] act_resp,
                          input bit is_wr);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s scoreboard empty actual_resp=%0d", name, act_resp);
    end else begin
      e = sb.pop_front();
      if (!is_wr) checkOutput({name, " rdata"}, act_data, e.data);
      checkOutput({name, " resp"}, {30'd0, act_resp}, {30'd0, e.resp});
    end
  endtask

  // order: 0 = AW and W together, 1 = AW one cycle first, 2 = W one cycle first.
  task automatic writeTxn(input string name, input logic [6:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int order, input int stall, input bit poke);
    int n;
    bit aw_pend, w_pend, aw_fire, w_fire;
    awaddr = addr; wdata = data; wstrb = strb;
    aw_pend = 1'b1; w_pend = 1'b1;
    awvalid = (order != 2);
    wvalid  = (order != 1);
    n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_fire) begin aw_pend = 1'b0; awvalid = 1'b0; end
      if (w_fire)  begin w_pend  = 1'b0; wvalid  = 1'b0; end
      if (!aw_pend && w_pend) wvalid = 1'b1;
      if (!w_pend && aw_pend) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput({name, " aw/w accepted"}, {30'd0, aw_pend, w_pend}, 32'd0);
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput({name, " bvalid latency"}, n, 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        awaddr = 7'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput({name, " stall bvalid/awready/wready"}, {29'd0, bvalid, awready, wready}, 32'h4);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    popCheck(name, 32'd0, bresp, 1'b1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    checkOutput({name, " after B"}, {29'd0, bvalid, awready, wready}, 32'h3);
  endtask

  task automatic readTxn(input string name, input logic [6:0] addr);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput({name, " rvalid latency"}, n, 32'd0);
    checkOutput({name, " arready low"}, {31'd0, arready}, 32'd0);
    popCheck(name, rdata, rresp, 1'b0);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checkOutput({name, " after R"}, {30'd0, rvalid, arready}, 32'h1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string name;
    exp_t  e;
    name = $sformatf("vec%0d", idx);
    e.data = v.exp_data;
    e.resp = v.exp_resp;
    sb.push_back(e);
    if (v.is_wr) writeTxn(name, v.addr, v.data, v.strb, v.order, 0, 1'b0);
    else         readTxn(name, v.addr);
    checkOutput({name, " ctrl"}, {26'd0, fifo_en, sel_source, sel_fir}, {26'd0, v.exp_ctrl});
  endtask

  task automatic pushExp(input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.data = d;
    e.resp = r;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // {is_wr, addr, wdata, wstrb, order, exp rdata, exp resp, exp {fifo_en, sel_source, sel_fir}}
    vecs.push_back(mk(0, 7'h00, 0, 0, 0, CORE_ID_V, OKAY, 6'b0_00_000));
    vecs.push_back(mk(0, 7'h04, 0, 0, 0, DATE_V, OKAY, 6'b0_00_000));
    vecs.push_back(mk(0, 7'h08, 0, 0, 0, 32'h0, OKAY, 6'b0_00_000));
    vecs.push_back(mk(1, 7'h08, 32'h1, 4'hF, 1, 0, OKAY, 6'b1_00_000));
    vecs.push_back(mk(0, 7'h08, 0, 0, 0, 32'h1, OKAY, 6'b1_00_000));
    vecs.push_back(mk(1, 7'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, OKAY, 6'b1_00_000));
    vecs.push_back(mk(0, 7'h10, 0, 0, 0, 32'h0, OKAY, 6'b1_00_000));
    vecs.push_back(mk(1, 7'h10, 32'hFFFF_FFFF, 4'h1, 2, 0, OKAY, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h10, 0, 0, 0, 32'h7, OKAY, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h18, 0, 0, 0, 32'h0, SLVERR, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h40, 0, 0, 0, 32'h0, SLVERR, 6'b1_00_111));
    vecs.push_back(mk(1, 7'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, OKAY, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h00, 0, 0, 0, CORE_ID_V, OKAY, 6'b1_00_111));
    vecs.push_back(mk(1, 7'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, SLVERR, 6'b1_00_111));
    vecs.push_back(mk(1, 7'h48, 32'h0, 4'hF, 1, 0, SLVERR, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h08, 0, 0, 0, 32'h1, OKAY, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h0B, 0, 0, 0, 32'h1, OKAY, 6'b1_00_111));
    vecs.push_back(mk(1, 7'h0C, 32'h3, 4'b0010, 0, 0, OKAY, 6'b1_00_111));
    vecs.push_back(mk(0, 7'h0C, 0, 0, 0, 32'h0, OKAY, 6'b1_00_111));
    vecs.push_back(mk(1, 7'h0C, 32'h1, 4'hF, 2, 0, OKAY, 6'b1_01_111));
    vecs.push_back(mk(0, 7'h0F, 0, 0, 0, 32'h1, OKAY, 6'b1_01_111));
    vecs.push_back(mk(0, 7'h14, 0, 0, 0, 32'h0, SCR ? OKAY : SLVERR, 6'b1_01_111));
    vecs.push_back(mk(1, 7'h14, 32'hA5A5_5A5A, 4'hF, 0, 0, SCR ? OKAY : SLVERR, 6'b1_01_111));
    vecs.push_back(mk(0, 7'h14, 0, 0, 0, SCR ? 32'hA5A5_5A5A : 32'h0, SCR ? OKAY : SLVERR, 6'b1_01_111));
    vecs.push_back(mk(1, 7'h14, 32'hFFFF_FFFF, 4'b0100, 1, 0, SCR ? OKAY : SLVERR, 6'b1_01_111));
    vecs.push_back(mk(0, 7'h14, 0, 0, 0, SCR ? 32'hA5FF_5A5A : 32'h0, SCR ? OKAY : SLVERR, 6'b1_01_111));
    vecs.push_back(mk(0, 7'h1C, 0, 0, 0, 32'h0, SLVERR, 6'b1_01_111));

    #12;
    checkOutput("reset handshakes", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
    checkOutput("reset resp", {28'd0, bresp, rresp}, 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset ctrl", {26'd0, fifo_en, sel_source, sel_fir}, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // bready held low: response must stay put and a second write must not get in
    pushExp(32'd0, OKAY);
    writeTxn("stall", 7'h0C, 32'h2, 4'hF, 0, 5, 1'b1);
    checkOutput("stall sel_source", {30'd0, sel_source}, 32'h2);
    pushExp(32'h2, OKAY);
    readTxn("stall readback", 7'h0C);

    // read and write of SEL_FIR in the same cycle: read sees the old value
    pushExp(32'h7, OKAY);
    pushExp(32'h0, OKAY);
    araddr = 7'h10; arvalid = 1'b1;
    awaddr = 7'h10; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("simul rvalid/bvalid", {30'd0, rvalid, bvalid}, 32'h3);
    popCheck("simul read", rdata, rresp, 1'b0);
    popCheck("simul write", 32'd0, bresp, 1'b1);
    checkOutput("simul sel_fir", {29'd0, sel_fir}, 32'h2);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    checkOutput("simul release", {27'd0, rvalid, bvalid, arready, awready, wready}, 32'h07);

    // reset while a read response is waiting for rready
    araddr = 7'h08; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    checkOutput("pre-reset rvalid", {31'd0, rvalid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset handshakes", {27'd0, rvalid, arready, awready, wready, bvalid}, 32'h0E);
    checkOutput("async reset ctrl", {26'd0, fifo_en, sel_source, sel_fir}, 32'd0);
    checkOutput("async reset rdata", rdata, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    pushExp(32'h0, OKAY);
    readTxn("post-reset fifo", 7'h08);
    pushExp(32'h0, OKAY);
    readTxn("post-reset src", 7'h0C);
    pushExp(32'h0, OKAY);
    readTxn("post-reset fir", 7'h10);
    pushExp(CORE_ID_V, OKAY);
    readTxn("post-reset id", 7'h00);
    pushExp(32'h0, SCR ? OKAY : SLVERR);
    readTxn("post-reset scratch", 7'h14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
